// File: rtl/fix2flt_pkg.sv
// fix2flt_pkg: shared types and constants for the 8.8 fixed-point to
// IEEE-754 half-precision converter (fix2flt_seq) and its bench.
//   state_e    : converter FSM states
//   BIAS       : half-precision exponent bias
//   FRAC_BITS  : fractional bits of the 8.8 input
//   EXP_INIT   : exponent value for a magnitude already normalised at bit 15
//   SIGN_W / EXP_W / MANT_W : half-float field widths
package fix2flt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      PACK = 2'd2
   } state_e;

   localparam int BIAS      = 15;
   localparam int FRAC_BITS = 8;
   localparam int EXP_INIT  = BIAS + 15 - FRAC_BITS;

   localparam int SIGN_W = 1;
   localparam int EXP_W  = 5;
   localparam int MANT_W = 10;
   localparam int FIX_W  = 16;

endpackage

// File: rtl/fix2flt_seq.sv
// fix2flt_seq: sequential signed 8.8 fixed point -> IEEE-754 half converter.
// Normalises by one left shift per clock, truncates the mantissa.
// Ports:
//   Clk    in   system clock, rising edge
//   Reset  in   synchronous active-high reset
//   Start  in   conversion request, only sampled in IDLE
//   FixIn  in   16-bit signed 8.8 operand, captured on the Start edge
//   FltOut out  16-bit half result, held until the next conversion packs
//   Busy   out  high while in NORM or PACK
//   Return out  one-cycle done pulse, high during the PACK cycle
module fix2flt_seq #(
   parameter int BIAS      = fix2flt_pkg::BIAS,
   parameter int FRAC_BITS = fix2flt_pkg::FRAC_BITS
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] FixIn,
   output logic [15:0] FltOut,
   output logic        Busy,
   output logic        Return
);
   import fix2flt_pkg::*;

   localparam logic [EXP_W-1:0] EXP_START = EXP_W'(BIAS + 15 - FRAC_BITS);

   state_e           state_q, state_d;
   logic             sign_q,  sign_d;
   logic [15:0]      mag_q,   mag_d;
   logic [EXP_W-1:0] exp_q,   exp_d;
   // Set once mag_q holds |FixIn|; until then mag_q holds the raw operand.
   logic             abs_q,   abs_d;
   logic [15:0]      flt_q,   flt_d;
   logic             busy_q,  busy_d;
   logic             ret_q,   ret_d;

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      mag_d   = mag_q;
      exp_d   = exp_q;
      abs_d   = abs_q;
      flt_d   = flt_q;

      case (state_q)
         IDLE: begin
            if (Start) begin
               sign_d  = FixIn[15];
               mag_d   = FixIn;
               exp_d   = EXP_START;
               abs_d   = 1'b0;
               state_d = NORM;
            end
         end
         NORM: begin
            if (!abs_q) begin
               // Negation is taken in the first NORM cycle so the 16-bit
               // carry chain never sits on the FixIn input path. 0x8000
               // negates to itself, which is the correct unsigned magnitude.
               mag_d = sign_q ? (~mag_q + 16'd1) : mag_q;
               abs_d = 1'b1;
            end else if ((mag_q == 16'd0) || mag_q[15]) begin
               state_d = PACK;
               // Zero never carries the sign: no negative zero out.
               flt_d   = (mag_q == 16'd0) ? 16'h0000
                                          : {sign_q, exp_q, mag_q[14:5]};
            end else begin
               mag_d = mag_q << 1;
               exp_d = exp_q - EXP_W'(1);
            end
         end
         PACK:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      ret_d  = (state_d == PACK);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         mag_q   <= 16'd0;
         exp_q   <= '0;
         abs_q   <= 1'b0;
         flt_q   <= 16'h0000;
         busy_q  <= 1'b0;
         ret_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         mag_q   <= mag_d;
         exp_q   <= exp_d;
         abs_q   <= abs_d;
         flt_q   <= flt_d;
         busy_q  <= busy_d;
         ret_q   <= ret_d;
      end
   end

   assign FltOut = flt_q;
   assign Busy   = busy_q;
   assign Return = ret_q;

endmodule

// File: tb/tb_fix2flt_seq.sv
// tb_fix2flt_seq: directed bench for fix2flt_seq. Each conversion checks
// busy after Start, FltOut hold, result value, Return latency, and the
// single-cycle Return / idle return afterwards.
module tb_fix2flt_seq;
   import fix2flt_pkg::*;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [15:0] FixIn;
   logic [15:0] FltOut;
   logic        Busy;
   logic        Return;

   int          tests;
   int          fails;
   logic [15:0] prev;

   fix2flt_seq dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Start  (Start),
      .FixIn  (FixIn),
      .FltOut (FltOut),
      .Busy   (Busy),
      .Return (Return)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One conversion. fx_after replaces FixIn after the Start edge; pulse
   // re-asserts Start at edges 3 and 5 while the converter is busy.
   task automatic convert(input string tag, input logic [15:0] fx, input logic [15:0] fx_after,
                          input logic [15:0] exp_flt, input int exp_lat, input bit pulse);
      int lat;
      lat = 0;
      @(negedge Clk);
      Start = 1'b1;
      FixIn = fx;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      FixIn = fx_after;
      chk({tag, ".busy"}, 32'(Busy), 32'd1);
      chk({tag, ".hold"}, 32'(FltOut), 32'(prev));
      for (int n = 1; n <= 20; n++) begin
         @(posedge Clk);
         #1;
         if (Return) begin
            lat = n;
            break;
         end
         Start = pulse && (n == 2 || n == 4);
      end
      Start = 1'b0;
      chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".flt"}, 32'(FltOut), 32'(exp_flt));
      @(posedge Clk);
      #1;
      chk({tag, ".ret_off"}, 32'(Return), 32'd0);
      chk({tag, ".idle"},    32'(Busy),   32'd0);
      prev = exp_flt;
   endtask

   initial begin
      int nret;
      tests = 0;
      fails = 0;
      prev  = 16'h0000;
      Reset = 1'b1;
      Start = 1'b0;
      FixIn = 16'h0000;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst.flt",  32'(FltOut), 32'h0000);
      chk("rst.busy", 32'(Busy),   32'd0);
      chk("rst.ret",  32'(Return), 32'd0);
      Reset = 1'b0;

      // Consecutive calls start in the first IDLE cycle after PACK.
      convert("p1",     16'h0100, 16'h0100, 16'h3C00,  9, 1'b0);
      convert("m1",     16'hFF00, 16'hFF00, 16'hBC00,  9, 1'b0);
      convert("p1_5",   16'h0180, 16'h0180, 16'h3E00,  9, 1'b0);
      convert("lsb",    16'h0001, 16'h0001, 16'h1C00, 17, 1'b0);
      convert("min",    16'h8000, 16'h8000,
              {1'b1, EXP_W'(EXP_INIT), MANT_W'(0)},  2, 1'b0);
      convert("max",    16'h7FFF, 16'h7FFF, 16'h57FF,  3, 1'b0);
      convert("negtr",  16'h8001, 16'h8001, 16'hD7FF,  3, 1'b0);
      convert("zero",   16'h0000, 16'h0000, 16'h0000,  2, 1'b0);
      convert("latch",  16'h0180, 16'h1234, 16'h3E00,  9, 1'b0);
      convert("ignore", 16'h0001, 16'h0001, 16'h1C00, 17, 1'b1);

      // Reset in the middle of a 0x0001 conversion.
      @(negedge Clk);
      Start = 1'b1;
      FixIn = 16'h0001;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("abort.pre_busy", 32'(Busy),   32'd1);
      chk("abort.pre_flt",  32'(FltOut), 32'h1C00);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      chk("abort.busy", 32'(Busy),   32'd0);
      chk("abort.flt",  32'(FltOut), 32'h0000);
      chk("abort.ret",  32'(Return), 32'd0);
      nret = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge Clk);
         #1;
         if (Return) nret++;
      end
      chk("abort.no_ret", 32'(nret), 32'd0);
      prev = 16'h0000;
      convert("after", 16'h0100, 16'h0100, 16'h3C00, 9, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
